wb_conbus_slv_dec: RTL and testbench
====================================

Name: wb_conbus_slv_dec

Overview:
Target-side companion to the conbus master arbiter. Takes the single granted master's Wishbone bus, decodes the address to one of 3 slaves, and latches that selection for the transfer. It drives the selected slave's cyc/stb, muxes read data and ack/err back to the master, and answers unmapped or hung accesses with err. Sits between the arbiter's master mux and the slave ports.

Parameters:
AW, 32, address width
DW, 32, data width
S0_BASE, 32'h0000_0000, slave 0 base address
S0_MASK, 32'hF000_0000, slave 0 match mask
S1_BASE, 32'h1000_0000, slave 1 base address
S1_MASK, 32'hF000_0000, slave 1 match mask
S2_BASE, 32'h2000_0000, slave 2 base address
S2_MASK, 32'hF000_0000, slave 2 match mask
TIMEOUT, 255, cycles in ACCESS before forced err (TIMEOUT_EN only); 8-bit counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
m_cyc_i  in  1  master cycle
m_stb_i  in  1  master strobe
m_we_i  in  1  master write enable
m_adr_i  in  AW  master address
m_sel_i  in  DW/8  byte selects
m_dat_i  in  DW  master write data
m_dat_o  out  DW  read data to master
m_ack_o  out  1  ack to master
m_err_o  out  1  err to master
s_cyc_o  out  3  per-slave cyc, one-hot
s_stb_o  out  3  per-slave stb, one-hot
s_we_o  out  1  broadcast we
s_adr_o  out  AW  broadcast address
s_sel_o  out  DW/8  broadcast byte selects
s_dat_o  out  DW  broadcast write data
s_dat_i  in  3*DW  slave read data, slave n at [n*DW +: DW]
s_ack_i  in  3  slave acks
s_err_i  in  3  slave errs

Behaviour:
- Reset (rst=0, async): state=IDLE, sel=0, counter=0. m_ack_o, m_err_o, s_cyc_o, s_stb_o = 0. m_dat_o = 0.
- Match rule: hit_n = ((m_adr_i & Sn_MASK) == Sn_BASE). Fixed priority if several hit: 0 > 1 > 2.
- States: IDLE, ACCESS, ERR.
- IDLE: on m_cyc_i & m_stb_i, register the one-hot sel.
  - If any hit: go to ACCESS.
  - If no hit: go to ERR.
  - Otherwise stay in IDLE.
- ACCESS: s_cyc_o = s_stb_o = sel while m_cyc_i & m_stb_i. Otherwise both are 0 and the FSM returns to IDLE (abort; no ack/err).
- ACCESS termination: on s_ack_i/s_err_i of the selected slave, m_ack_o/m_err_o follow combinationally in that same cycle and the FSM returns to IDLE. Acks/errs from unselected slaves are ignored.
- ERR: m_err_o=1 for exactly one cycle (if m_cyc_i & m_stb_i are still high), then IDLE.
- Latency: 1 decode cycle. Slave stb is first seen the cycle after master stb. Each beat re-decodes, so the minimum transfer is 2 cycles per beat.
- m_dat_o: s_dat_i slice of the selected slave while in ACCESS, else 0.
- s_we_o, s_adr_o, s_sel_o, s_dat_o: pass-through of master signals, unregistered.
- Simultaneous selected ack and err: err wins; m_ack_o is suppressed.
- Master changes its address mid-ACCESS: the latched sel is kept.
- Reset asserted mid-transfer: all strobes drop immediately.

Optional Feature:
WB_CONBUS_DEC_TIMEOUT_EN
- Defined: the counter clears on entry to ACCESS and increments each cycle in ACCESS. When it reaches TIMEOUT with no ack/err, the block drops the slave strobe, pulses m_err_o for 1 cycle and returns to IDLE.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Shared package (wb_conbus_pkg): state encodings IDLE/ACCESS/ERR (2 bits), slave count NSLV=3, default base/mask constants.
- One sub-module: wb_conbus_addr_match (combinational mask/base compare, returns one-hot priority hit and a miss flag).
- FSM, counter and response mux stay in the top module.

Test Plan:
1. Read slave 1: adr=0x1000_0040, stb held; slave 1 acks 2 cycles after its stb with dat=0xCAFEF00D. Expect s_stb_o=3'b010 from cycle 1, and m_ack_o with m_dat_o=0xCAFEF00D in the ack cycle.
2. Unmapped adr=0x3000_0000 -> m_err_o for 1 cycle at cycle 1; s_stb_o stays 0.
3. Master drops stb in ACCESS before ack -> s_stb_o=0 that cycle, FSM in IDLE next cycle, no m_ack_o. A later slave-0 ack with sel=slave1 is ignored.
4. Selected slave asserts ack and err together -> m_err_o=1, m_ack_o=0.
5. With WB_CONBUS_DEC_TIMEOUT_EN and TIMEOUT=4, slave 2 never acks -> m_err_o after 4 ACCESS cycles, s_stb_o back to 0.
6. Drive rst=0 mid-ACCESS -> all outputs 0 asynchronously. After release, an access to slave 0 completes normally.

Source files
------------

// File: rtl/wb_conbus_pkg.sv
// Shared definitions for the conbus slave-side decoder: FSM states, slave count
// and default slave address windows.
package wb_conbus_pkg;

  localparam int unsigned NSLV = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StErr    = 2'd2
  } state_e;

  localparam logic [31:0] S0BaseDef = 32'h0000_0000;
  localparam logic [31:0] S0MaskDef = 32'hF000_0000;
  localparam logic [31:0] S1BaseDef = 32'h1000_0000;
  localparam logic [31:0] S1MaskDef = 32'hF000_0000;
  localparam logic [31:0] S2BaseDef = 32'h2000_0000;
  localparam logic [31:0] S2MaskDef = 32'hF000_0000;

endpackage

// File: rtl/wb_conbus_addr_match.sv
// Combinational address decoder: mask/base compare per slave, one-hot hit with
// fixed priority (slave 0 highest) and a miss flag when nothing matches.
module wb_conbus_addr_match
  import wb_conbus_pkg::*;
#(
  parameter int unsigned     AW      = 32,
  parameter logic [AW-1:0]   S0_BASE = AW'(S0BaseDef),
  parameter logic [AW-1:0]   S0_MASK = AW'(S0MaskDef),
  parameter logic [AW-1:0]   S1_BASE = AW'(S1BaseDef),
  parameter logic [AW-1:0]   S1_MASK = AW'(S1MaskDef),
  parameter logic [AW-1:0]   S2_BASE = AW'(S2BaseDef),
  parameter logic [AW-1:0]   S2_MASK = AW'(S2MaskDef)
) (
  input  logic [AW-1:0]   adr_i,
  output logic [NSLV-1:0] hit_o,
  output logic            miss_o
);

  logic [NSLV-1:0] raw;

  assign raw[0] = ((adr_i & S0_MASK) == S0_BASE);
  assign raw[1] = ((adr_i & S1_MASK) == S1_BASE);
  assign raw[2] = ((adr_i & S2_MASK) == S2_BASE);

  always_comb begin
    hit_o = '0;
    if (raw[0]) begin
      hit_o = 3'b001;
    end else if (raw[1]) begin
      hit_o = 3'b010;
    end else if (raw[2]) begin
      hit_o = 3'b100;
    end
  end

  assign miss_o = ~|raw;

endmodule

// File: rtl/wb_conbus_slv_dec.sv
// Wishbone slave-side decoder: latches the decoded slave per beat, routes cyc/stb
// and muxes data/ack/err back. Optional access timeout: WB_CONBUS_DEC_TIMEOUT_EN.
module wb_conbus_slv_dec
  import wb_conbus_pkg::*;
#(
  parameter int unsigned   AW      = 32,
  parameter int unsigned   DW      = 32,
  parameter logic [AW-1:0] S0_BASE = AW'(S0BaseDef),
  parameter logic [AW-1:0] S0_MASK = AW'(S0MaskDef),
  parameter logic [AW-1:0] S1_BASE = AW'(S1BaseDef),
  parameter logic [AW-1:0] S1_MASK = AW'(S1MaskDef),
  parameter logic [AW-1:0] S2_BASE = AW'(S2BaseDef),
  parameter logic [AW-1:0] S2_MASK = AW'(S2MaskDef),
  parameter int unsigned   TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m_cyc_i,
  input  logic                m_stb_i,
  input  logic                m_we_i,
  input  logic [AW-1:0]       m_adr_i,
  input  logic [DW/8-1:0]     m_sel_i,
  input  logic [DW-1:0]       m_dat_i,
  output logic [DW-1:0]       m_dat_o,
  output logic                m_ack_o,
  output logic                m_err_o,
  output logic [NSLV-1:0]     s_cyc_o,
  output logic [NSLV-1:0]     s_stb_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_adr_o,
  output logic [DW/8-1:0]     s_sel_o,
  output logic [DW-1:0]       s_dat_o,
  input  logic [NSLV*DW-1:0]  s_dat_i,
  input  logic [NSLV-1:0]     s_ack_i,
  input  logic [NSLV-1:0]     s_err_i
);

  state_e          state_q, state_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic [NSLV-1:0] hit;
  logic            miss;
  logic            req, sel_ack, sel_err, tmo;
  logic [DW-1:0]   rdata;

  wb_conbus_addr_match #(
    .AW      (AW),
    .S0_BASE (S0_BASE),
    .S0_MASK (S0_MASK),
    .S1_BASE (S1_BASE),
    .S1_MASK (S1_MASK),
    .S2_BASE (S2_BASE),
    .S2_MASK (S2_MASK)
  ) u_addr_match (
    .adr_i  (m_adr_i),
    .hit_o  (hit),
    .miss_o (miss)
  );

  assign req     = m_cyc_i & m_stb_i;
  assign sel_ack = |(s_ack_i & sel_q);
  assign sel_err = |(s_err_i & sel_q);

  assign s_we_o  = m_we_i;
  assign s_adr_o = m_adr_i;
  assign s_sel_o = m_sel_i;
  assign s_dat_o = m_dat_i;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) rdata = rdata | s_dat_i[i*DW +: DW];
    end
  end

`ifdef WB_CONBUS_DEC_TIMEOUT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
  logic [7:0] cnt_q, cnt_d;

  // Held at zero outside ACCESS, so it reads zero on the first ACCESS cycle.
  assign cnt_d = (state_q == StAccess) ? cnt_q + 8'd1 : 8'd0;
  assign tmo   = (cnt_q == TimeoutCnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    s_cyc_o = '0;
    s_stb_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_dat_o = '0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          sel_d   = hit;
          state_d = miss ? StErr : StAccess;
        end
      end
      StAccess: begin
        m_dat_o = rdata;
        if (!req) begin
          state_d = StIdle;
        end else if (tmo) begin
          m_err_o = 1'b1;
          state_d = StIdle;
        end else begin
          s_cyc_o = sel_q;
          s_stb_o = sel_q;
          // Err takes precedence over a coincident ack.
          m_err_o = sel_err;
          m_ack_o = sel_ack & ~sel_err;
          if (sel_ack || sel_err) state_d = StIdle;
        end
      end
      StErr: begin
        m_err_o = req;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_wb_conbus_slv_dec.sv
// Self-checking bench for wb_conbus_slv_dec: directed scenarios plus randomized
// transactions checked against a per-transaction behavioural model.
module tb_wb_conbus_slv_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cyc_i, m_stb_i, m_we_i;
  logic [31:0] m_adr_i, m_dat_i, m_dat_o;
  logic [3:0]  m_sel_i, s_sel_o;
  logic        m_ack_o, m_err_o, s_we_o;
  logic [2:0]  s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [31:0] s_adr_o, s_dat_o;
  logic [95:0] s_dat_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_conbus_slv_dec #(
    .TIMEOUT (4)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_sel_i (m_sel_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_sel_o (s_sel_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i)
  );

  // Address windows are the top nibble 0/1/2; anything else is unmapped.
  function automatic int slave_of(input logic [31:0] adr);
    int top;
    top = int'(adr >> 28);
    return (top <= 2) ? top : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] e_stb, input logic e_ack,
                            input logic e_err, input logic [31:0] e_dat);
    chk({tag, " stb"}, 32'(s_stb_o), 32'(e_stb));
    chk({tag, " cyc"}, 32'(s_cyc_o), 32'(e_stb));
    chk({tag, " ack"}, 32'(m_ack_o), 32'(e_ack));
    chk({tag, " err"}, 32'(m_err_o), 32'(e_err));
    chk({tag, " dat"}, m_dat_o, e_dat);
    chk({tag, " adr_thru"}, s_adr_o, m_adr_i);
    chk({tag, " wdat_thru"}, s_dat_o, m_dat_i);
    chk({tag, " sel_thru"}, 32'(s_sel_o), 32'(m_sel_i));
    chk({tag, " we_thru"}, 32'(s_we_o), 32'(m_we_i));
  endtask

  task automatic idle_bus();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    s_ack_i = '0;
    s_err_i = '0;
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 master abort. lat = wait cycles in ACCESS.
  task automatic txn(input string tag, input logic [31:0] adr, input int lat, input int kind,
                     input logic [31:0] rdat);
    int         sidx;
    logic [2:0] oh;
    logic       e_ack, e_err;
    sidx = slave_of(adr);
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = adr;
    m_we_i  = 1'($urandom);
    m_sel_i = 4'($urandom);
    m_dat_i = $urandom;
    s_ack_i = '0;
    s_err_i = '0;
    s_dat_i = {$urandom, $urandom, $urandom};
    #1 check_outs({tag, " decode"}, 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    if (sidx < 0) begin
      #1 check_outs({tag, " unmapped"}, 3'b000, 1'b0, 1'b1, 32'h0);
      @(negedge clk);
    end else begin
      oh = 3'(1 << sidx);
      for (int j = 0; j <= lat; j++) begin
        if (j > 0) m_adr_i = $urandom;
        s_dat_i = {$urandom, $urandom, $urandom};
        s_dat_i[sidx*32 +: 32] = rdat;
        s_ack_i = 3'($urandom) & ~oh;
        s_err_i = 3'($urandom) & ~oh;
        if (j < lat) begin
          #1 check_outs({tag, " wait"}, oh, 1'b0, 1'b0, rdat);
        end else begin
          e_ack = 1'b0;
          e_err = 1'b0;
          case (kind)
            0: begin s_ack_i = s_ack_i | oh; e_ack = 1'b1; end
            1: begin s_err_i = s_err_i | oh; e_err = 1'b1; end
            2: begin s_ack_i = s_ack_i | oh; s_err_i = s_err_i | oh; e_err = 1'b1; end
            default: begin m_stb_i = 1'b0; s_ack_i = s_ack_i | oh; end
          endcase
          #1 check_outs({tag, " resp"}, (kind == 3) ? 3'b000 : oh, e_ack, e_err, rdat);
        end
        @(negedge clk);
      end
    end
    idle_bus();
    #1 check_outs({tag, " after"}, 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle_bus();
    m_adr_i = '0;
    m_we_i  = 1'b0;
    m_sel_i = '0;
    m_dat_i = '0;
    s_dat_i = '0;
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    txn("read_s1", 32'h1000_0040, 2, 0, 32'hCAFE_F00D);
    txn("unmapped", 32'h3000_0000, 0, 0, 32'h0);
    txn("abort_s1", 32'h1000_0000, 1, 3, 32'h1234_5678);
    txn("ackerr_s2", 32'h2000_0010, 0, 2, 32'h0BAD_BEEF);
    txn("err_s0", 32'h0000_0100, 1, 1, 32'h5555_AAAA);

`ifdef WB_CONBUS_DEC_TIMEOUT_EN
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = 32'h2000_0000;
    s_dat_i = {32'h0000_0022, 32'h0000_0011, 32'h0000_0000};
    #1 check_outs("tmo decode", 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      #1 check_outs("tmo wait", 3'b100, 1'b0, 1'b0, 32'h22);
      @(negedge clk);
    end
    #1 check_outs("tmo fire", 3'b000, 1'b0, 1'b1, 32'h22);
    @(negedge clk);
    idle_bus();
    #1 check_outs("tmo after", 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
`endif

    // Asynchronous reset in the middle of an access.
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_adr_i = 32'h1000_0000;
    s_dat_i = {32'h3, 32'hABCD_0001, 32'h1};
    @(negedge clk);
    #1 check_outs("pre_rst", 3'b010, 1'b0, 1'b0, 32'hABCD_0001);
    rst = 1'b0;
    #1 check_outs("mid_rst", 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    idle_bus();
    rst = 1'b1;
    @(negedge clk);
    txn("post_rst_s0", 32'h0000_0200, 1, 0, 32'h600D_0000);

    for (int n = 0; n < 60; n++) begin
      int          r;
      logic [3:0]  top;
      logic [31:0] adr;
      r   = int'($urandom_range(0, 5));
      top = (r < 3) ? 4'(r) : 4'($urandom_range(3, 15));
      adr = {top, 28'($urandom)};
      txn("rand", adr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
